// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types and sizes for the register-file write-port controller
package regfile_ctrl_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic {
        S_INIT = 1'b0,
        S_ARB  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr and wraps
// Ports: req (request vector), ptr (highest-priority index), en (allow any grant),
//        gnt (one-hot grant), idx (granted index), any (a grant was issued)
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr is always kept below NUM_REQ, so one subtraction is enough to wrap
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (en && !any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - register-file write-port controller with round-robin writeback and zero-clear
// Ports: clk_i, rst_ni (async active-low), clr_i (clear request),
//        req_valid_i/req_ready_o/req_addr_i/req_data_i (per-requester writeback handshake),
//        rd_wren/rd_addr/rd_data (registered register-file write port), busy_o (clear running)
module regfile_wb_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clr_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]         req_data_i,
    output logic                                 rd_wren,
    output logic [REG_ADDR_W-1:0]                rd_addr,
    output logic [XLEN-1:0]                      rd_data,
    output logic                                 busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(REG_COUNT - 1);

    state_e                state_q, state_d;
    logic [REG_ADDR_W-1:0] cnt_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic                  arb_en;

    // Grants are suppressed while clearing and in the cycle a clear is requested
    assign arb_en = (state_q == S_ARB) && !clr_i;
    assign busy_o = (state_q == S_INIT);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req (req_valid_i),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (req_ready_o),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: if (cnt_q == LAST_REG) state_d = S_ARB;
            S_ARB:  if (clr_i)             state_d = S_INIT;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            ptr_q   <= '0;
            rd_wren <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (state_q == S_INIT) begin
            rd_wren <= 1'b1;
            rd_addr <= cnt_q;
            rd_data <= '0;
            cnt_q   <= (cnt_q == LAST_REG) ? '0 : cnt_q + 1'b1;
        end else if (gnt_any) begin
            // x0 writes are accepted so the requester drains, but never reach the file
            rd_wren <= (req_addr_i[gnt_idx] != '0);
            rd_addr <= req_addr_i[gnt_idx];
            rd_data <= req_data_i[gnt_idx];
            ptr_q   <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end else begin
            rd_wren <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - scoreboard bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             clr_i;
    logic [2:0]       req_valid_i;
    logic [2:0]       req_ready_o;
    logic [2:0][4:0]  req_addr_i;
    logic [2:0][31:0] req_data_i;
    logic             rd_wren;
    logic [4:0]       rd_addr;
    logic [31:0]      rd_data;
    logic             busy_o;

    int n_vec = 0;
    int n_bad = 0;

    logic [36:0] exp_q[$];
    logic [31:0] rf [32] = '{default: 32'hA5A5_A5A5};

    always #5 clk_i = ~clk_i;

    regfile_wb_ctrl #(.NUM_REQ(3)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .rd_wren     (rd_wren),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy_o      (busy_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register-file model: captures whatever the DUT writes
    always @(posedge clk_i) begin
        if (rd_wren) rf[rd_addr] <= rd_data;
    end

    // Monitor: every presented write must match the head of the expected queue
    always @(negedge clk_i) begin
        if (rd_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_wr: got addr %0d data %0h expected no write", rd_addr, rd_data);
            end else begin
                chk("wr", {27'd0, rd_addr, rd_data}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_clear();
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 32'h0});
    endtask

    task automatic wait_grant(input int idx, input string nm);
        int t;
        t = 0;
        #1;
        while (req_ready_o[idx] !== 1'b1 && t < 60) begin
            @(negedge clk_i);
            #1;
            t++;
        end
        chk(nm, {61'd0, req_ready_o}, 64'(1) << idx);
        @(negedge clk_i);
        req_valid_i[idx] = 1'b0;
    endtask

    task automatic single_req(input int idx, input logic [4:0] a, input logic [31:0] d);
        req_addr_i[idx]  = a;
        req_data_i[idx]  = d;
        req_valid_i[idx] = 1'b1;
        wait_grant(idx, "single_ready");
    endtask

    int nz;

    initial begin
        rst_ni      = 1'b0;
        clr_i       = 1'b0;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_out", {rd_wren, rd_addr, rd_data}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd1);
        chk("rst_ready", {61'd0, req_ready_o}, 64'd0);

        // Power-on clear: 32 writes of zero, addresses ascending
        push_clear();
        rst_ni = 1'b1;
        req_valid_i = 3'b111;
        req_addr_i  = {5'd3, 5'd2, 5'd1};
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk_i);
            if (k < 32) begin
                chk("init_busy", {63'd0, busy_o}, 64'd1);
                chk("init_ready", {61'd0, req_ready_o}, 64'd0);
            end
        end
        req_valid_i = '0;
        chk("init_done_busy", {63'd0, busy_o}, 64'd0);
        chk("init_last", {58'd0, rd_wren, rd_addr}, {58'd0, 1'b1, 5'd31});

        // Single requester 1, then requester 2 to return ptr to 0
        single_req(1, 5'd5, 32'hDEAD_BEEF);
        chk("x5_wr", {rd_wren, rd_addr, rd_data}, {1'b1, 5'd5, 32'hDEAD_BEEF});
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        exp_q.push_back({5'd7, 32'h77});
        single_req(2, 5'd7, 32'h77);
        @(negedge clk_i);
        chk("x5_rf", {32'd0, rf[5]}, {32'd0, 32'hDEAD_BEEF});

        // All requesters continuously valid: 0,1,2,0,1,2 with no idle cycle
        for (int k = 0; k < 6; k++) exp_q.push_back({5'((k % 3) + 1), 32'((k % 3) + 1) * 32'h101});
        req_addr_i  = {5'd3, 5'd2, 5'd1};
        req_data_i  = {32'h303, 32'h202, 32'h101};
        req_valid_i = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_ready", {61'd0, req_ready_o}, 64'(1) << (k % 3));
            @(negedge clk_i);
            chk("rr_wr", {58'd0, rd_wren, rd_addr}, {58'd0, 1'b1, 5'((k % 3) + 1)});
            if (k == 5) req_valid_i = '0;
            #1;
        end

        // x0 write is accepted but suppressed
        single_req(0, 5'd0, 32'h1234);
        chk("x0_wren", {63'd0, rd_wren}, 64'd0);
        exp_q.push_back({5'd4, 32'h44});
        single_req(2, 5'd4, 32'h44);
        @(negedge clk_i);
        chk("x0_rf", {32'd0, rf[0]}, 64'd0);

        // Clear with pending requests: clear wins, then grants 0 then 2
        push_clear();
        exp_q.push_back({5'd9, 32'h99});
        exp_q.push_back({5'd10, 32'hAA});
        req_addr_i  = {5'd10, 5'd0, 5'd9};
        req_data_i  = {32'hAA, 32'h0, 32'h99};
        req_valid_i = 3'b101;
        clr_i       = 1'b1;
        #1;
        chk("clr_ready", {61'd0, req_ready_o}, 64'd0);
        @(negedge clk_i);
        clr_i = 1'b0;
        chk("clr_busy", {63'd0, busy_o}, 64'd1);
        wait_grant(0, "post_clr_g0");
        wait_grant(2, "post_clr_g2");
        repeat (2) @(negedge clk_i);
        chk("rf9", {32'd0, rf[9]}, 64'h99);
        chk("rf10", {32'd0, rf[10]}, 64'hAA);
        nz = 0;
        for (int i = 0; i < 32; i++) if (i != 9 && i != 10 && rf[i] != 0) nz++;
        chk("rf_zero_cnt", 64'(nz), 64'd0);

        // Reset during clear cycle 10, then a full restart
        for (int i = 0; i < 10; i++) exp_q.push_back({5'(i), 32'h0});
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("mid_clr_addr", {59'd0, rd_addr}, 64'd9);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst", {rd_wren, rd_addr, rd_data}, 64'd0);
        chk("async_rst_busy", {63'd0, busy_o}, 64'd1);
        chk("q_at_rst", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk_i);
        push_clear();
        rst_ni = 1'b1;
        repeat (33) @(negedge clk_i);
        chk("restart_busy", {63'd0, busy_o}, 64'd0);
        chk("q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
